pairing_host_if: RTL and testbench

Host-side sequencer for the Tate pairing core. It accepts the input operands one word at a time over a valid/ready stream and writes them into the core's operand RAM. It then releases the command FSM from reset and waits for it to raise `done`. Finally it reads the result words back from RAM and streams them out. The block owns the RAM's host-side port and the FSM's active-high reset, and it counts the cycles each run takes.

---
 rtl/pairing_host_if_if.sv | 30 +++
 rtl/pairing_host_if.sv | 125 ++++++++++++
 tb/tb_pairing_host_if.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pairing_host_if_if.sv
// Host-side bundle of the pairing sequencer: operand stream in, result stream out,
// and the host port of the core's operand RAM.
interface pairing_host_if_if #(
    parameter int unsigned WIDTH  = 194,
    parameter int unsigned ADDR_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic              ram_sel;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [WIDTH-1:0]  ram_wdata;
    logic [WIDTH-1:0]  ram_rdata;

    // Sequencer side
    modport slave (
        input  in_valid, in_data, out_ready, ram_rdata,
        output in_ready, out_valid, out_data, ram_sel, ram_addr, ram_we, ram_wdata
    );

    // Producer/consumer/RAM side
    modport master (
        output in_valid, in_data, out_ready, ram_rdata,
        input  in_ready, out_valid, out_data, ram_sel, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/pairing_host_if.sv
// Host sequencer for the Tate pairing core: loads operands into RAM, runs the
// command FSM, times the run and streams the result words back out.
module pairing_host_if #(
    parameter int unsigned       WIDTH    = 194,
    parameter int unsigned       ADDR_W   = 6,
    parameter int unsigned       N_IN     = 4,
    parameter logic [ADDR_W-1:0] IN_BASE  = ADDR_W'(32),
    parameter int unsigned       N_OUT    = 6,
    parameter logic [ADDR_W-1:0] OUT_BASE = ADDR_W'(40)
) (
    input  logic                clk,
    input  logic                reset,
    pairing_host_if_if.slave    bus,
    output logic                fsm_reset,
    input  logic                fsm_done,
    output logic                busy,
    output logic [31:0]         run_cycles
);

    localparam logic [ADDR_W-1:0] LAST_IN  = ADDR_W'(N_IN - 1);
    localparam logic [ADDR_W-1:0] LAST_OUT = ADDR_W'(N_OUT - 1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_RUN,
        S_READ,
        S_CAP,
        S_OUT
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [31:0]       run_cycles_q, run_cycles_d;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_LOAD;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            run_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            run_cycles_q <= run_cycles_d;
        end
    end

    // Next state and decoded RAM/FSM controls; the core is held in reset outside RUN
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        run_cycles_d   = run_cycles_q;
        bus.in_ready   = 1'b0;
        bus.ram_sel    = 1'b1;
        bus.ram_addr   = '0;
        bus.ram_we     = 1'b0;
        bus.ram_wdata  = '0;
        fsm_reset      = 1'b1;
        busy           = 1'b1;

        case (state_q)
            S_LOAD: begin
                busy         = 1'b0;
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    bus.ram_we    = 1'b1;
                    bus.ram_addr  = IN_BASE + cnt_q;
                    bus.ram_wdata = bus.in_data;
                    if (cnt_q == LAST_IN) begin
                        cnt_d        = '0;
                        run_cycles_d = '0;
                        state_d      = S_RUN;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
            S_RUN: begin
                fsm_reset   = 1'b0;
                bus.ram_sel = 1'b0;
                if (fsm_done) begin
                    state_d = S_READ;
                end else if (run_cycles_q != '1) begin
                    run_cycles_d = run_cycles_q + 32'd1;
                end
            end
            S_READ: begin
                bus.ram_addr = OUT_BASE + cnt_q;
                state_d      = S_CAP;
            end
            S_CAP: begin
                out_data_d  = bus.ram_rdata;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (cnt_q == LAST_OUT) begin
                        cnt_d   = '0;
                        state_d = S_LOAD;
                    end else begin
                        cnt_d   = cnt_q + ONE;
                        state_d = S_READ;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign run_cycles    = run_cycles_q;

endmodule

// File: tb/tb_pairing_host_if.sv
// Scoreboard bench for pairing_host_if with a behavioural RAM and a stub command
// FSM that writes derived results and raises done after a programmable delay.
module tb_pairing_host_if;

    localparam int unsigned WIDTH  = 194;
    localparam int unsigned ADDR_W = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fsm_reset;
    logic        fsm_done;
    logic        busy;
    logic [31:0] run_cycles;

    pairing_host_if_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    pairing_host_if dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .fsm_reset  (fsm_reset),
        .fsm_done   (fsm_done),
        .busy       (busy),
        .run_cycles (run_cycles)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_acc = 0;
    int acc_in_run = 0;
    bit gap_chk = 1'b0;
    int done_delay = 100;
    int stub_cnt = 0;

    logic [WIDTH-1:0]  mem [0:63];
    logic [WIDTH-1:0]  wq_data[$];
    logic [ADDR_W-1:0] wq_addr[$];
    logic [WIDTH-1:0]  oq[$];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [WIDTH-1:0] rnd_word();
        return WIDTH'({$urandom(), $urandom(), $urandom(), $urandom(),
                       $urandom(), $urandom(), $urandom()});
    endfunction

    // What the stub core computes from the four operands
    function automatic logic [WIDTH-1:0] res_f(input int i, input logic [WIDTH-1:0] a0,
                                               input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] a2,
                                               input logic [WIDTH-1:0] a3);
        logic [WIDTH-1:0] a [4];
        a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
        return a[i % 4] ^ (a[(i + 1) % 4] << i) ^ WIDTH'(i + 1);
    endfunction

    assign fsm_done = !fsm_reset && (stub_cnt >= done_delay);

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM (host port) plus stub core writing results on its first cycle
    always @(posedge clk) begin
        if (bus.ram_sel && bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        if (bus.ram_sel) bus.ram_rdata <= mem[bus.ram_addr];
        if (!fsm_reset && stub_cnt == 0)
            for (int i = 0; i < 6; i++)
                mem[40 + i] <= res_f(i, mem[32], mem[33], mem[34], mem[35]);
        stub_cnt <= fsm_reset ? 0 : stub_cnt + 1;
    end

    // Monitor: RAM writes and result handshakes against the scoreboard queues
    always @(negedge clk) begin
        if (bus.ram_we) begin
            if (wq_addr.size() == 0) begin
                check("spurious_write", bus.ram_we, 0);
            end else begin
                check("wr_addr", bus.ram_addr, wq_addr.pop_front());
                check("wr_data", bus.ram_wdata, wq_data.pop_front());
            end
        end
        if (bus.out_valid && bus.out_ready) begin
            if (oq.size() == 0) check("spurious_out", bus.out_valid, 0);
            else check("out_data", bus.out_data, oq.pop_front());
            if (gap_chk && acc_in_run != 0) check("out_gap", cyc - last_acc, 3);
            last_acc = cyc;
            acc_in_run++;
        end
    end

    task automatic load_words(input bit gapped);
        logic [WIDTH-1:0] a [4];
        for (int i = 0; i < 4; i++) begin
            a[i] = rnd_word();
            wq_addr.push_back(ADDR_W'(32 + i));
            wq_data.push_back(a[i]);
        end
        for (int i = 0; i < 6; i++) oq.push_back(res_f(i, a[0], a[1], a[2], a[3]));
        acc_in_run = 0;
        for (int i = 0; i < 4; i++) begin
            if (gapped) begin
                bus.in_valid = 1'b0;
                bus.in_data  = rnd_word();
                @(posedge clk); #1;
                check("gap_busy", busy, 0);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = a[i];
            @(posedge clk); #1;
        end
        // keep offering data: it must be ignored outside LOAD
        bus.in_valid = 1'b1;
        bus.in_data  = rnd_word();
        check("run_fsm_reset", fsm_reset, 0);
        check("run_busy", busy, 1);
        check("run_in_ready", bus.in_ready, 0);
        check("run_ram_sel", bus.ram_sel, 0);
    endtask

    task automatic wait_read(input int dly);
        int n = 0;
        while (!fsm_reset && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        bus.in_valid = 1'b0;
        check("read_reached", fsm_reset, 1);
        check("read_addr", bus.ram_addr, 40);
        check("read_ram_sel", bus.ram_sel, 1);
        check("run_cycles", run_cycles, dly);
        check("read_busy", busy, 1);
    endtask

    task automatic drain(input int stall_idx, input int stall_len);
        int n = 0;
        bit stalled = 1'b0;
        gap_chk = (stall_idx < 0);
        bus.out_ready = 1'b1;
        while (acc_in_run < 6 && n < 2000) begin
            if (acc_in_run == stall_idx && !stalled) begin
                bus.out_ready = 1'b0;
                stalled = 1'b1;
                while (!bus.out_valid && n < 2000) begin
                    @(posedge clk); #1;
                    n++;
                end
                repeat (stall_len) begin
                    check("stall_valid", bus.out_valid, 1);
                    check("stall_data", bus.out_data, oq.size() > 0 ? oq[0] : '0);
                    check("stall_addr", bus.ram_addr, 0);
                    @(posedge clk); #1;
                    n++;
                end
                bus.out_ready = 1'b1;
            end
            @(posedge clk); #1;
            n++;
        end
        check("drain_count", acc_in_run, 6);
        check("idle_busy", busy, 0);
        check("idle_in_ready", bus.in_ready, 1);
        check("idle_fsm_reset", fsm_reset, 1);
        check("idle_out_valid", bus.out_valid, 0);
        bus.out_ready = 1'b0;
        gap_chk = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_run_cycles", run_cycles, 0);
        check("rst_busy", busy, 0);
        check("rst_fsm_reset", fsm_reset, 1);
        check("rst_ram_sel", bus.ram_sel, 1);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_ram_we", bus.ram_we, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // back-to-back load, 100-cycle run, free-flowing readback
        done_delay = 100;
        load_words(1'b0);
        wait_read(100);
        drain(-1, 0);

        // gapped load, done on first RUN cycle, backpressure on R2
        done_delay = 0;
        load_words(1'b1);
        wait_read(0);
        drain(2, 10);

        // reset during RUN
        done_delay = 500;
        load_words(1'b0);
        bus.in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("mid_run_fsm_reset", fsm_reset, 1);
        check("mid_run_out_valid", bus.out_valid, 0);
        check("mid_run_cycles", run_cycles, 0);
        check("mid_run_busy", busy, 0);
        oq.delete();
        @(posedge clk); #1;
        reset = 1'b1;

        // reset during OUT
        done_delay = 3;
        load_words(1'b0);
        wait_read(3);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("pre_abort_valid", bus.out_valid, 1);
        reset = 1'b0;
        #1;
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_out_data", bus.out_data, 0);
        check("abort_fsm_reset", fsm_reset, 1);
        check("abort_in_ready", bus.in_ready, 1);
        oq.delete();
        @(posedge clk); #1;
        reset = 1'b1;

        // full run after abort
        done_delay = 37;
        load_words(1'b0);
        wait_read(37);
        drain(-1, 0);

        check("wq_empty", wq_addr.size(), 0);
        check("oq_empty", oq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
